// File: rtl/booth_divider_if.sv
// rtl/booth_divider_if.sv - start/done handshake bundle for the signed divider
//
// Purpose: groups the operand, result and handshake signals shared between
// the divider and whatever drives it.
// Signals:
//   start   begin a division (driven by master)
//   data_N  dividend, two's complement (driven by master)
//   data_D  divisor, two's complement (driven by master)
//   quot    quotient, truncated toward zero (driven by slave)
//   rem     remainder, sign of dividend (driven by slave)
//   done    one-cycle completion pulse (driven by slave)
//   busy    operation in progress (driven by slave)
//   dbz     divide-by-zero flag (driven by slave)
//   ovf     overflow flag for -2^(N-1) / -1 (driven by slave)
// Modports: master (requester side), slave (divider side).
interface booth_divider_if #(
  parameter int N = 4
) ();
  logic         start;
  logic [N-1:0] data_N;
  logic [N-1:0] data_D;
  logic [N-1:0] quot;
  logic [N-1:0] rem;
  logic         done;
  logic         busy;
  logic         dbz;
  logic         ovf;

  modport master (
    output start, data_N, data_D,
    input  quot, rem, done, busy, dbz, ovf
  );

  modport slave (
    input  start, data_N, data_D,
    output quot, rem, done, busy, dbz, ovf
  );
endinterface

// File: rtl/booth_divider.sv
// rtl/booth_divider.sv - sequential signed non-restoring divider
//
// Purpose: computes quotient and remainder of two N-bit two's-complement
// operands, one quotient bit per ITER cycle, using a controller FSM and an
// A/Q/M/count datapath.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; aborts any operation in progress
//   bus  booth_divider_if.slave: start/data_N/data_D in,
//        quot/rem/done/busy/dbz/ovf out (all outputs registered)
// Optional build macro: DIV_DBZ_FASTPATH_EN - a zero divisor skips the
// ITER phase and goes straight from LOAD to FIX (latency 3 instead of N+3).
module booth_divider #(
  parameter int N = 4
) (
  input logic            clk,
  input logic            rst,
  booth_divider_if.slave bus
);

  localparam int CNT_W = $clog2(N + 1);
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state;

  // Operands captured on the accepted start edge.
  logic [N-1:0]     n_reg;
  logic [N-1:0]     d_reg;

  // Datapath: A is one bit wider than the magnitudes so its MSB is the sign.
  logic [N:0]       a_reg;
  logic [N-1:0]     q_reg;
  logic [N-1:0]     m_reg;
  logic [CNT_W-1:0] count;
  logic             sign_n;
  logic             sign_x;
  logic             dbz_int;

  // Combinational helpers.
  logic [N-1:0]     n_abs;
  logic [N-1:0]     d_abs;
  logic [N:0]       m_ext;
  logic [N:0]       a_shift;
  logic [N:0]       a_step;
  logic [N:0]       a_fix;
  logic [N-1:0]     q_neg;
  logic [N-1:0]     r_mag;
  logic [N-1:0]     r_neg;
  logic             ovf_cond;

  always_comb begin
    // |-2^(N-1)| wraps to 2^(N-1), which is correct when read as unsigned.
    n_abs    = n_reg[N-1] ? -n_reg : n_reg;
    d_abs    = d_reg[N-1] ? -d_reg : d_reg;
    m_ext    = {1'b0, m_reg};
    a_shift  = {a_reg[N-1:0], q_reg[N-1]};
    // Non-restoring step: the sign of A before the shift picks add or subtract.
    a_step   = a_reg[N] ? (a_shift + m_ext) : (a_shift - m_ext);
    // A negative final partial remainder still carries one extra -M.
    a_fix    = a_reg[N] ? (a_reg + m_ext) : a_reg;
    r_mag    = a_fix[N-1:0];
    q_neg    = -q_reg;
    r_neg    = -r_mag;
    ovf_cond = (n_reg == MIN_VAL) && (d_reg == {N{1'b1}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      n_reg    <= '0;
      d_reg    <= '0;
      a_reg    <= '0;
      q_reg    <= '0;
      m_reg    <= '0;
      count    <= '0;
      sign_n   <= 1'b0;
      sign_x   <= 1'b0;
      dbz_int  <= 1'b0;
      bus.quot <= '0;
      bus.rem  <= '0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
      bus.dbz  <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            n_reg    <= bus.data_N;
            d_reg    <= bus.data_D;
            bus.busy <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          sign_n  <= n_reg[N-1];
          sign_x  <= n_reg[N-1] ^ d_reg[N-1];
          q_reg   <= n_abs;
          m_reg   <= d_abs;
          a_reg   <= '0;
          count   <= CNT_W'(N);
          dbz_int <= (d_reg == '0);
          // Flags of the previous result are dropped once a new op starts.
          bus.dbz <= 1'b0;
          bus.ovf <= 1'b0;
`ifdef DIV_DBZ_FASTPATH_EN
          state   <= (d_reg == '0) ? FIX : ITER;
`else
          state   <= ITER;
`endif
        end

        ITER: begin
          a_reg <= a_step;
          q_reg <= {q_reg[N-2:0], ~a_step[N]};
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            state <= FIX;
          end
        end

        FIX: begin
          a_reg <= a_fix;
          if (dbz_int) begin
            bus.quot <= {N{1'b1}};
            bus.rem  <= n_reg;
            bus.dbz  <= 1'b1;
            bus.ovf  <= 1'b0;
          end else if (ovf_cond) begin
            bus.quot <= MIN_VAL;
            bus.rem  <= '0;
            bus.ovf  <= 1'b1;
          end else begin
            bus.quot <= sign_x ? q_neg : q_reg;
            bus.rem  <= sign_n ? r_neg : r_mag;
          end
          bus.busy <= 1'b0;
          state    <= DONE;
        end

        DONE: begin
          bus.done <= 1'b1;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// tb/tb_booth_divider.sv - directed self-checking bench for booth_divider
module tb_booth_divider;
  localparam int N = 4;

`ifdef DIV_DBZ_FASTPATH_EN
  localparam int DBZ_LAT = 3;
`else
  localparam int DBZ_LAT = N + 3;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  booth_divider_if #(.N(N)) bus ();

  booth_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [N-1:0] n, input logic [N-1:0] d);
    bus.data_N = n;
    bus.data_D = d;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
  endtask

  // Returns the number of edges after the start edge until done is seen,
  // or -1 if the budget runs out.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [N-1:0] n, input logic [N-1:0] d,
                     input logic [N-1:0] eq, input logic [N-1:0] er,
                     input logic edbz, input logic eovf, input int elat);
    int lat;
    start_op(n, d);
    wait_done(lat);
    check({tag, " latency"}, lat, elat);
    check({tag, " quot"}, bus.quot, eq);
    check({tag, " rem"}, bus.rem, er);
    check({tag, " dbz"}, bus.dbz, edbz);
    check({tag, " ovf"}, bus.ovf, eovf);
    check({tag, " busy at done"}, bus.busy, 1'b0);
    @(posedge clk);
    #1;
    check({tag, " done pulse width"}, bus.done, 1'b0);
  endtask

  initial begin
    int pulses;
    logic [N-1:0] q_seen;
    logic [N-1:0] r_seen;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.data_N = '0;
    bus.data_D = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset quot", bus.quot, 4'b0000);
    check("reset rem", bus.rem, 4'b0000);
    check("reset done", bus.done, 1'b0);
    check("reset busy", bus.busy, 1'b0);
    check("reset dbz", bus.dbz, 1'b0);
    check("reset ovf", bus.ovf, 1'b0);

    // start together with rst: rst wins, nothing starts
    bus.data_N = 4'd7;
    bus.data_D = 4'd2;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    rst       = 1'b0;
    check("rst beats start busy", bus.busy, 1'b0);

    run("7/2",   4'd7,    4'd2,    4'b0011, 4'b0001, 1'b0, 1'b0, 7);
    run("-7/2",  4'b1001, 4'd2,    4'b1101, 4'b1111, 1'b0, 1'b0, 7);
    run("7/-2",  4'd7,    4'b1110, 4'b1101, 4'b0001, 1'b0, 1'b0, 7);
    run("-8/-1", 4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b1, 7);
    run("-8/3",  4'b1000, 4'd3,    4'b1110, 4'b1110, 1'b0, 1'b0, 7);
    run("5/0",   4'd5,    4'd0,    4'b1111, 4'b0101, 1'b1, 1'b0, DBZ_LAT);
    run("-6/4",  4'b1010, 4'd4,    4'b1111, 4'b1110, 1'b0, 1'b0, 7);

    // Second start during ITER must be ignored
    start_op(4'd6, 4'd3);
    check("busy in LOAD", bus.busy, 1'b1);
    @(posedge clk);
    #1;
    bus.data_N = 4'd1;
    bus.data_D = 4'd1;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    pulses = 0;
    q_seen = '0;
    r_seen = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        pulses++;
        q_seen = bus.quot;
        r_seen = bus.rem;
      end
    end
    check("ignored start pulses", pulses, 1);
    check("ignored start quot", q_seen, 4'b0010);
    check("ignored start rem", r_seen, 4'b0000);

    // Reset in the second ITER cycle aborts the operation
    start_op(4'd7, 4'd2);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort busy", bus.busy, 1'b0);
    check("abort done", bus.done, 1'b0);
    check("abort quot", bus.quot, 4'b0000);
    check("abort rem", bus.rem, 4'b0000);

    run("6/4 after abort", 4'd6, 4'd4, 4'b0001, 4'b0010, 1'b0, 1'b0, 7);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
